// File: rtl/spart_tx_fifo.sv
// ============================================================================
// Module      : spart_tx_fifo
// Description : SPART transmit path. A DEPTH-entry byte FIFO feeding a
//               start/data/parity/stop serialiser paced by the BRGEN tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_tx_fifo #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TICKS_PER_BIT = 16,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BITS-1:0]         trans_buff,
  input  logic                         trans_load,
  input  logic                         BRGEN,
  input  logic                         clr_ovr,
  output logic                         TxD,
  output logic                         TBR,
  output logic                         tx_empty,
  output logic                         ovr,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [FW-1:0] FULL      = FW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]  shift;
  logic                  par_bit;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  pop, push, bit_end;

  // A write into a full FIFO still fits when the serialiser frees a slot this cycle.
  assign push     = trans_load & ((fill != FULL) | pop);
  assign bit_end  = BRGEN & (tick_cnt == TICK_LAST);
  assign TBR      = (fill != FULL);
  assign tx_empty = (fill == '0) & (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    TxD       = 1'b1;
    case (state)
      S_IDLE: begin
        if (fill != '0) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        TxD = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        TxD = shift[0];
        if (bit_end && (bit_cnt == DATA_LAST))
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        TxD = par_bit;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next frame when data is waiting.
        if (bit_end && (bit_cnt == STOP_LAST)) begin
          if (fill != '0) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trans_buff;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      ovr    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (trans_load && !push) ovr <= 1'b1;
      else if (clr_ovr)        ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      par_bit  <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        shift    <= mem[rd_ptr];
        par_bit  <= (PARITY == 2) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if ((state != S_IDLE) && BRGEN) begin
        if (bit_end) begin
          tick_cnt <= '0;
          bit_cnt  <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
          if (state == S_DATA) shift <= shift >> 1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
